// File: rtl/clk_pkg.sv
// Shared definitions for the clock datapath: BCD digit type, widths and
// packed-BCD helper functions used by every counter field.
package clk_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam int         MAX_NDIG = 4;
    localparam int         MAX_W    = BCD_W * MAX_NDIG;

    typedef logic [BCD_W-1:0] bcd_digit_t;
    typedef logic [MAX_W-1:0] bcd_vec_t;

    // Narrower fields are zero-extended by the caller; zero nibbles are valid.
    function automatic logic bcd_valid(input bcd_vec_t v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_NDIG; i++) begin
            if (v[i*BCD_W +: BCD_W] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Unsigned a < b, taken from the borrow of a widened subtraction.
    function automatic logic bcd_lt(input bcd_vec_t a, input bcd_vec_t b);
        logic [MAX_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[MAX_W];
    endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// Single BCD digit step: increments or decrements d when cin is set and
// reports the carry/borrow into the next more significant digit.
module bcd_digit
    import clk_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       up,
    input  logic       cin,
    output bcd_digit_t d_next,
    output logic       cout
);

    always_comb begin
        d_next = d;
        cout   = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= BCD_MAX) begin
                    d_next = '0;
                    cout   = 1'b1;
                end else begin
                    d_next = d + 4'd1;
                end
            end else begin
                if (d == '0) begin
                    d_next = BCD_MAX;
                    cout   = 1'b1;
                end else begin
                    d_next = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter (MIN_VAL..MAX_VAL) with up/down count,
// checked synchronous load and a combinational cascade terminal count.
module bcd_mod_counter
    import clk_pkg::*;
#(
    parameter int                NDIG    = 2,
    parameter logic [4*NDIG-1:0] MIN_VAL = '0,
    parameter logic [4*NDIG-1:0] MAX_VAL = 8'h23
) (
    input  logic              CP,
    input  logic              CLR,
    input  logic              EN,
    input  logic              UP,
    input  logic              LD,
    input  logic [4*NDIG-1:0] DIN,
    output logic [4*NDIG-1:0] Q,
    output logic              CO,
    output logic              LDERR
);

    localparam int W = BCD_W * NDIG;

    logic [W-1:0]  r_q;
    logic          r_lderr;
    logic [W-1:0]  w_q_next;
    logic          w_lderr_next;
    logic [W-1:0]  w_step;
    logic [NDIG:0] w_carry;
    logic          w_q_legal;
    logic          w_din_legal;
    logic          w_at_max;
    logic          w_at_min;
    logic          w_at_term;
    logic          w_wrap;

    // Ripple chain: digit 0 always steps, higher digits step on carry/borrow.
    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            bcd_digit u_digit (
                .d      (r_q[gi*BCD_W +: BCD_W]),
                .up     (UP),
                .cin    (w_carry[gi]),
                .d_next (w_step[gi*BCD_W +: BCD_W]),
                .cout   (w_carry[gi+1])
            );
        end
    endgenerate

    assign w_q_legal   = bcd_valid(bcd_vec_t'(r_q))
                       && !bcd_lt(bcd_vec_t'(r_q), bcd_vec_t'(MIN_VAL))
                       && !bcd_lt(bcd_vec_t'(MAX_VAL), bcd_vec_t'(r_q));
    assign w_din_legal = bcd_valid(bcd_vec_t'(DIN))
                       && !bcd_lt(bcd_vec_t'(DIN), bcd_vec_t'(MIN_VAL))
                       && !bcd_lt(bcd_vec_t'(MAX_VAL), bcd_vec_t'(DIN));

    assign w_at_max  = (r_q == MAX_VAL);
    assign w_at_min  = (r_q == MIN_VAL);
    assign w_at_term = UP ? w_at_max : w_at_min;
    // A carry out of the top digit only happens at a range end, so it also wraps.
    assign w_wrap    = w_at_term | w_carry[NDIG];

    assign CO = EN & ~LD & w_at_term;

    always_comb begin
        w_q_next     = r_q;
        w_lderr_next = 1'b0;
        if (LD) begin
            if (w_din_legal) begin
                w_q_next = DIN;
            end else begin
                w_q_next     = MIN_VAL;
                w_lderr_next = 1'b1;
            end
        end else if (EN) begin
            if (!w_q_legal) begin
                w_q_next = MIN_VAL;
            end else if (w_wrap) begin
                w_q_next = UP ? MIN_VAL : MAX_VAL;
            end else begin
                w_q_next = w_step;
            end
        end
    end

    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            r_q     <= MIN_VAL;
            r_lderr <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_lderr <= w_lderr_next;
        end
    end

    assign Q     = r_q;
    assign LDERR = r_lderr;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Randomised and directed checks of bcd_mod_counter against a decimal
// arithmetic reference model; four instances incl. a seconds->days cascade.
module tb_bcd_mod_counter;

    localparam int A_MIN = 0, A_MAX = 23;
    localparam int B_MIN = 1, B_MAX = 12;
    localparam int S_MIN = 0, S_MAX = 59;
    localparam int D_MIN = 1, D_MAX = 365;

    logic        clk = 1'b0;
    logic        clr;
    logic        a_en, a_up, a_ld, a_co, a_err;
    logic [7:0]  a_din, a_q;
    logic        b_en, b_up, b_ld, b_co, b_err;
    logic [7:0]  b_din, b_q;
    logic        s_en, s_up, s_ld, s_co, s_err;
    logic [7:0]  s_din, s_q;
    logic        d_up, d_ld, d_co, d_err;
    logic [11:0] d_din, d_q;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] ma, mb, ms, md;
    bit          ea, eb, es, ed;

    always #5 clk = ~clk;

    bcd_mod_counter dut_a (
        .CP(clk), .CLR(clr), .EN(a_en), .UP(a_up), .LD(a_ld), .DIN(a_din),
        .Q(a_q), .CO(a_co), .LDERR(a_err)
    );

    bcd_mod_counter #(.NDIG(2), .MIN_VAL(8'h01), .MAX_VAL(8'h12)) dut_b (
        .CP(clk), .CLR(clr), .EN(b_en), .UP(b_up), .LD(b_ld), .DIN(b_din),
        .Q(b_q), .CO(b_co), .LDERR(b_err)
    );

    bcd_mod_counter #(.NDIG(2), .MIN_VAL(8'h00), .MAX_VAL(8'h59)) dut_s (
        .CP(clk), .CLR(clr), .EN(s_en), .UP(s_up), .LD(s_ld), .DIN(s_din),
        .Q(s_q), .CO(s_co), .LDERR(s_err)
    );

    bcd_mod_counter #(.NDIG(3), .MIN_VAL(12'h001), .MAX_VAL(12'h365)) dut_d (
        .CP(clk), .CLR(clr), .EN(s_co), .UP(d_up), .LD(d_ld), .DIN(d_din),
        .Q(d_q), .CO(d_co), .LDERR(d_err)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit legal(input logic [15:0] v, input int mn, input int mx);
        for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return (bcd2int(v) >= mn) && (bcd2int(v) <= mx);
    endfunction

    function automatic bit exp_co(input logic [15:0] q, input bit en, input bit ld, input bit up,
                                  input int mn, input int mx);
        return en && !ld && (up ? (q == int2bcd(mx)) : (q == int2bcd(mn)));
    endfunction

    // Reference counter step in decimal arithmetic.
    function automatic void mstep(input logic [15:0] q, input bit ld, input bit en, input bit up,
                                  input logic [15:0] din, input int mn, input int mx,
                                  output logic [15:0] qn, output bit err);
        int v;
        qn  = q;
        err = 1'b0;
        if (ld) begin
            if (legal(din, mn, mx)) qn = din;
            else begin
                qn  = int2bcd(mn);
                err = 1'b1;
            end
        end else if (en) begin
            if (!legal(q, mn, mx)) qn = int2bcd(mn);
            else begin
                v = bcd2int(q);
                if (up) v = (v == mx) ? mn : v + 1;
                else    v = (v == mn) ? mx : v - 1;
                qn = int2bcd(v);
            end
        end
    endfunction

    function automatic logic [15:0] rand_din(input int mn, input int mx, input int w);
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 1);
        case ($urandom_range(0, 3))
            0:       return 16'($urandom) & mask;
            1:       return ($urandom_range(0, 1) == 1) ? int2bcd(mx + 1) : int2bcd(mn);
            default: return int2bcd(int'($urandom_range(mn, mx)));
        endcase
    endfunction

    task automatic reset_models();
        ma = int2bcd(A_MIN); mb = int2bcd(B_MIN); ms = int2bcd(S_MIN); md = int2bcd(D_MIN);
        ea = 0; eb = 0; es = 0; ed = 0;
    endtask

    // One clock: check CO before the edge, advance the model, check Q/LDERR after.
    task automatic tick(input string tag);
        bit ca, cb, cs, cd;
        logic [15:0] na, nb, ns, nd;
        bit xa, xb, xs, xd;
        #1;
        if (clr) reset_models();
        ca = exp_co(ma, a_en, a_ld, a_up, A_MIN, A_MAX);
        cb = exp_co(mb, b_en, b_ld, b_up, B_MIN, B_MAX);
        cs = exp_co(ms, s_en, s_ld, s_up, S_MIN, S_MAX);
        cd = exp_co(md, cs, d_ld, d_up, D_MIN, D_MAX);
        check_eq({tag, "/a_co"}, 16'(a_co), 16'(ca));
        check_eq({tag, "/b_co"}, 16'(b_co), 16'(cb));
        check_eq({tag, "/s_co"}, 16'(s_co), 16'(cs));
        check_eq({tag, "/d_co"}, 16'(d_co), 16'(cd));
        mstep(ma, a_ld, a_en, a_up, 16'(a_din), A_MIN, A_MAX, na, xa);
        mstep(mb, b_ld, b_en, b_up, 16'(b_din), B_MIN, B_MAX, nb, xb);
        mstep(ms, s_ld, s_en, s_up, 16'(s_din), S_MIN, S_MAX, ns, xs);
        mstep(md, d_ld, cs,   d_up, 16'(d_din), D_MIN, D_MAX, nd, xd);
        @(posedge clk);
        #1;
        if (clr) reset_models();
        else begin
            ma = na; mb = nb; ms = ns; md = nd;
            ea = xa; eb = xb; es = xs; ed = xd;
        end
        check_eq({tag, "/a_q"}, 16'(a_q), ma);
        check_eq({tag, "/a_lderr"}, 16'(a_err), 16'(ea));
        check_eq({tag, "/b_q"}, 16'(b_q), mb);
        check_eq({tag, "/b_lderr"}, 16'(b_err), 16'(eb));
        check_eq({tag, "/s_q"}, 16'(s_q), ms);
        check_eq({tag, "/s_lderr"}, 16'(s_err), 16'(es));
        check_eq({tag, "/d_q"}, 16'(d_q), md);
        check_eq({tag, "/d_lderr"}, 16'(d_err), 16'(ed));
        $display("txn %s: a=%h b=%h s=%h d=%h lderr=%b%b%b%b", tag, a_q, b_q, s_q, d_q,
                 a_err, b_err, s_err, d_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1;
        a_en = 0; a_up = 0; a_ld = 0; a_din = '0;
        b_en = 0; b_up = 0; b_ld = 0; b_din = '0;
        s_en = 0; s_up = 0; s_ld = 0; s_din = '0;
        d_up = 0; d_ld = 0; d_din = '0;
        reset_models();
        #2;
        check_eq("rst_a_q", 16'(a_q), 16'h0000);
        check_eq("rst_b_q", 16'(b_q), 16'h0001);
        check_eq("rst_d_q", 16'(d_q), 16'h0001);
        check_eq("rst_a_lderr", 16'(a_err), 16'h0000);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Up-count through the full 00..23 range and wrap.
        a_en = 1; a_up = 1;
        for (int i = 0; i < 24; i++) begin
            tick("upwrap");
            check_eq("upwrap_seq", 16'(a_q), int2bcd((i + 1) % 24));
        end
        check_eq("upwrap_end", 16'(a_q), 16'h0000);
        a_en = 0;

        // Down-wrap and borrow on the 01..12 field.
        b_en = 1; b_up = 0;
        #1;
        check_eq("down_co_at_min", 16'(b_co), 16'h0001);
        tick("down");
        check_eq("down_wrap", 16'(b_q), 16'h0012);
        tick("down");
        check_eq("down_11", 16'(b_q), 16'h0011);
        tick("down");
        tick("down");
        check_eq("down_borrow", 16'(b_q), 16'h0009);
        b_en = 0;

        // Loads: legal, bad digit, out of range.
        a_ld = 1; a_din = 8'h17;
        tick("load");
        check_eq("load_ok_q", 16'(a_q), 16'h0017);
        check_eq("load_ok_err", 16'(a_err), 16'h0000);
        a_din = 8'h1A;
        tick("load");
        check_eq("load_digit_q", 16'(a_q), 16'h0000);
        check_eq("load_digit_err", 16'(a_err), 16'h0001);
        a_ld = 0;
        tick("load");
        check_eq("lderr_pulse_end", 16'(a_err), 16'h0000);
        a_ld = 1; a_din = 8'h24;
        tick("load");
        check_eq("load_range_err", 16'(a_err), 16'h0001);

        // LD beats EN; CO is masked during a load even at MAX.
        a_din = 8'h23;
        tick("prio");
        a_en = 1; a_up = 1; a_din = 8'h20;
        #1;
        check_eq("prio_co_masked", 16'(a_co), 16'h0000);
        tick("prio");
        check_eq("prio_load_wins", 16'(a_q), 16'h0020);
        a_ld = 0;
        tick("prio");

        // Asynchronous clear mid-cycle, held across an edge.
        #2;
        clr = 1'b1;
        #1;
        check_eq("clr_async_a", 16'(a_q), 16'h0000);
        check_eq("clr_async_b", 16'(b_q), 16'h0001);
        tick("clr");
        check_eq("clr_hold_a", 16'(a_q), 16'h0000);
        clr = 1'b0;
        a_en = 0;

        // Illegal held state: holds with EN=0, recovers to MIN with EN=1.
        force dut_a.r_q = 8'h3F;
        #1;
        release dut_a.r_q;
        ma = 16'h003F;
        check_eq("illegal_forced", 16'(a_q), 16'h003F);
        tick("illegal");
        check_eq("illegal_hold", 16'(a_q), 16'h003F);
        a_en = 1; a_up = 0;
        tick("illegal");
        check_eq("illegal_recover", 16'(a_q), 16'h0000);
        a_en = 0;

        // Cascade seconds -> days.
        s_en = 1; s_up = 1; d_up = 1;
        for (int i = 0; i < 125; i++) tick("cascade");
        check_eq("cascade_two_wraps", 16'(d_q), 16'h0003);
        s_ld = 1; s_din = 8'h59; d_ld = 1; d_din = 12'h099;
        tick("cascade");
        s_ld = 0; d_ld = 0;
        tick("cascade");
        check_eq("cascade_099_100", 16'(d_q), 16'h0100);
        s_ld = 1; s_din = 8'h59; d_ld = 1; d_din = 12'h365;
        tick("cascade");
        s_ld = 0; d_ld = 0;
        tick("cascade");
        check_eq("cascade_365_001", 16'(d_q), 16'h0001);

        // Randomised traffic on all instances.
        for (int i = 0; i < 400; i++) begin
            a_ld = ($urandom_range(0, 7) == 0); a_en = ($urandom_range(0, 3) != 0);
            a_up = 1'($urandom); a_din = 8'(rand_din(A_MIN, A_MAX, 8));
            b_ld = ($urandom_range(0, 7) == 0); b_en = ($urandom_range(0, 3) != 0);
            b_up = 1'($urandom); b_din = 8'(rand_din(B_MIN, B_MAX, 8));
            s_ld = ($urandom_range(0, 9) == 0); s_en = ($urandom_range(0, 3) != 0);
            s_up = 1'($urandom); s_din = 8'(rand_din(S_MIN, S_MAX, 8));
            d_ld = ($urandom_range(0, 9) == 0);
            d_up = 1'($urandom); d_din = 12'(rand_din(D_MIN, D_MAX, 12));
            clr  = ($urandom_range(0, 49) == 0);
            tick("rand");
            clr = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
